osd_cdm_du_bridge: RTL and testbench
====================================

Name: osd_cdm_du_bridge

Overview:
- Downstream neighbour of the core debug module (CDM). It turns the CDM's decoded SPR register requests into cycle-accurate transactions on the CPU debug-unit (du_*) bus.
- Owns the CPU stall line: combines the host stall request with a latched breakpoint hold.
- Detects breakpoint hits and raises a single pending event toward the CDM's event packetizer.
- Bounds every du_* access with a timeout so the debug interconnect cannot hang.

Parameters:
- TIMEOUT_CYCLES, 256, maximum cycles du_stb_i stays high without du_ack_o before the access aborts with an error; must be >= 2.
- REQUIRE_STALL, 1, when 1 SPR access is refused unless du_stall_i is currently 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  SPR access request from CDM
- req_ready  out  1  bridge accepts request
- req_write  in  1  1=write, 0=read
- req_addr  in  16  SPR address, already upper-extended by CDM
- req_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  CDM consumes response
- rsp_rdata  out  32  read data (0 on write or error)
- rsp_err  out  1  access refused or timed out
- cpu_stall_req  in  1  host stall register value
- stall_release  in  1  single-cycle pulse; clears breakpoint hold
- du_stall_i  out  1  stall to CPU
- du_stall_o  in  1  CPU reports breakpoint/stalled
- du_stb_i  out  1  debug bus strobe
- du_ack_o  in  1  debug bus acknowledge
- du_adr_i  out  16  debug bus address
- du_we_i  out  1  debug bus write enable
- du_dat_i  out  32  debug bus write data
- du_dat_o  in  32  debug bus read data
- bp_event_valid  out  1  breakpoint event pending
- bp_event_ready  in  1  event consumed
- bp_overflow  out  1  more than one hit was coalesced into the pending event

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, bp_hold=0, pending event cleared, timeout counter 0. An in-flight access is dropped without a response.
- FSM state IDLE:
  - req_ready=1.
  - On req_valid with REQUIRE_STALL=1 and du_stall_i=0: latch err=1 and rdata=0, then go to RESP. du_stb_i is never asserted.
  - Otherwise: register addr, wdata and write into du_adr_i, du_dat_i and du_we_i; du_stb_i goes to 1 the next cycle; go to ACCESS.
- FSM state ACCESS:
  - req_ready=0, du_stb_i=1, counter increments each cycle.
  - If du_ack_o=1: capture du_dat_o into rsp_rdata on a read (0 on a write), err=0, drop du_stb_i the next cycle, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: drop du_stb_i, err=1, rdata=0, go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins.
- FSM state RESP:
  - rsp_valid=1, with data and err held stable until rsp_ready.
  - On rsp_ready: go to IDLE and clear the counter.
  - req_ready stays 0 throughout.
- Latency: request accepted in cycle 0, strobe in cycle 1, earliest ack in cycle 1, rsp_valid in cycle 2.
- du_adr_i, du_we_i and du_dat_i are stable for the whole time du_stb_i is high. They return to 0 in IDLE.
- Stall logic:
  - A rising edge of du_stall_o (registered previous value) sets bp_hold.
  - stall_release clears bp_hold. If release and a rising edge happen in the same cycle, the set wins.
  - du_stall_i = registered (cpu_stall_req | bp_hold), so it is one cycle after its inputs.
- Breakpoint events:
  - A rising edge of du_stall_o sets bp_event_valid.
  - bp_event_valid && bp_event_ready clears the pending event and bp_overflow.
  - A rising edge while an event is already pending keeps it pending and sets bp_overflow.
  - A rising edge in the same cycle as a handshake leaves the event pending with bp_overflow=0.

Decomposition:
- Package osd_cdm_pkg holds:
  - the bridge state enum (IDLE, ACCESS, RESP);
  - constants CDM_SPR_ADDR_W=16 and CDM_SPR_DATA_W=32;
  - the request/response struct typedefs shared with the CDM.
- One sub-module, osd_cdm_bp_event, contains:
  - du_stall_o edge detection;
  - the bp_hold set/clear logic;
  - the pending-event register and overflow flag with its handshake.
- The top level holds the access FSM and timeout counter.

Test Plan:
- cpu_stall_req=1, wait 2 cycles, read addr 0x0010, ack after 3 strobe cycles with du_dat_o=0xDEADBEEF -> du_stb_i high exactly 3 cycles, du_adr_i=0x0010, du_we_i=0, rsp_rdata=0xDEADBEEF, rsp_err=0.
- REQUIRE_STALL=1, cpu_stall_req=0, write 0x0020 with data 0x12345678 -> du_stb_i never 1, rsp_valid with rsp_err=1 and rsp_rdata=0.
- TIMEOUT_CYCLES=8, stalled core, read with no ack -> du_stb_i high 8 cycles then 0, rsp_err=1, rsp_rdata=0; hold rsp_ready=0 for 5 cycles and check the response stays stable.
- cpu_stall_req=0, pulse du_stall_o 0->1 -> bp_event_valid=1 next cycle; du_stall_i=1 and stays 1 until a stall_release pulse, then 0 one cycle later.
- Two du_stall_o rising edges with bp_event_ready=0 -> one pending event with bp_overflow=1; one bp_event_ready cycle -> both bits clear.
- Assert rst during ACCESS at cycle 2 of the strobe -> all outputs 0 on the next cycle, no rsp_valid, and the next request completes normally.

Source files
------------

// File: rtl/osd_cdm_pkg.sv
// Shared types and constants for the CDM SPR path and the CPU debug-unit bridge.
//   CDM_SPR_ADDR_W / CDM_SPR_DATA_W : SPR address and data widths
//   bridge_state_e                  : access FSM states of osd_cdm_du_bridge
//   spr_req_t / spr_rsp_t           : request and response payloads exchanged with the CDM
package osd_cdm_pkg;

  localparam int unsigned CDM_SPR_ADDR_W = 16;
  localparam int unsigned CDM_SPR_DATA_W = 32;

  typedef enum logic [1:0] {
    BR_IDLE   = 2'd0,
    BR_ACCESS = 2'd1,
    BR_RESP   = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic                      write;
    logic [CDM_SPR_ADDR_W-1:0] addr;
    logic [CDM_SPR_DATA_W-1:0] wdata;
  } spr_req_t;

  typedef struct packed {
    logic                      err;
    logic [CDM_SPR_DATA_W-1:0] rdata;
  } spr_rsp_t;

endpackage

// File: rtl/osd_cdm_du_bridge_if.sv
// SPR request/response handshake from the CDM plus the CPU debug-unit (du_*) bus.
//   req_*/rsp_*                : CDM SPR access request and response
//   du_stb_i/du_adr_i/du_we_i/
//   du_dat_i/du_ack_o/du_dat_o : debug-unit bus (names follow the CPU's view)
// Modport slave is the bridge: it serves CDM requests and drives the du bus.
// Modport master is the surrounding system: CDM requester and CPU bus target.
interface osd_cdm_du_bridge_if;
  import osd_cdm_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [CDM_SPR_ADDR_W-1:0] req_addr;
  logic [CDM_SPR_DATA_W-1:0] req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [CDM_SPR_DATA_W-1:0] rsp_rdata;
  logic                      rsp_err;

  logic                      du_stb_i;
  logic                      du_ack_o;
  logic [CDM_SPR_ADDR_W-1:0] du_adr_i;
  logic                      du_we_i;
  logic [CDM_SPR_DATA_W-1:0] du_dat_i;
  logic [CDM_SPR_DATA_W-1:0] du_dat_o;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, du_ack_o, du_dat_o,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, du_stb_i, du_adr_i, du_we_i, du_dat_i
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, du_ack_o, du_dat_o,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, du_stb_i, du_adr_i, du_we_i, du_dat_i
  );

endinterface

// File: rtl/osd_cdm_bp_event.sv
// Breakpoint detection, CPU stall ownership and the pending breakpoint event.
//   clk, rst        : clock, synchronous active-high reset
//   cpu_stall_req   : host stall register value
//   stall_release   : pulse clearing the breakpoint hold
//   du_stall_o      : CPU reports breakpoint/stalled
//   du_stall_i      : registered stall to the CPU
//   bp_event_valid  : breakpoint event pending toward the packetizer
//   bp_event_ready  : event consumed
//   bp_overflow     : more than one hit coalesced into the pending event
module osd_cdm_bp_event (
  input  logic clk,
  input  logic rst,
  input  logic cpu_stall_req,
  input  logic stall_release,
  input  logic du_stall_o,
  output logic du_stall_i,
  output logic bp_event_valid,
  input  logic bp_event_ready,
  output logic bp_overflow
);

  logic stall_o_q,  stall_o_d;
  logic bp_hold_q,  bp_hold_d;
  logic stall_i_q,  stall_i_d;
  logic ev_valid_q, ev_valid_d;
  logic ev_ovf_q,   ev_ovf_d;
  logic rise;
  logic ev_hs;

  // Next-state for hold, stall and event registers.
  always_comb begin
    stall_o_d  = du_stall_o;
    bp_hold_d  = bp_hold_q;
    ev_valid_d = ev_valid_q;
    ev_ovf_d   = ev_ovf_q;

    rise  = du_stall_o & ~stall_o_q;
    ev_hs = ev_valid_q & bp_event_ready;

    // Set has priority over release.
    if (stall_release) bp_hold_d = 1'b0;
    if (rise)          bp_hold_d = 1'b1;

    // Fed from the next hold value so a hit or release reaches the CPU one cycle later.
    stall_i_d = cpu_stall_req | bp_hold_d;

    if (ev_hs) begin
      ev_valid_d = 1'b0;
      ev_ovf_d   = 1'b0;
    end
    // A hit landing on a consume cycle starts a fresh event without overflow.
    if (rise) begin
      ev_valid_d = 1'b1;
      if (ev_valid_q && !ev_hs) ev_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_o_q  <= 1'b0;
      bp_hold_q  <= 1'b0;
      stall_i_q  <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_ovf_q   <= 1'b0;
    end else begin
      stall_o_q  <= stall_o_d;
      bp_hold_q  <= bp_hold_d;
      stall_i_q  <= stall_i_d;
      ev_valid_q <= ev_valid_d;
      ev_ovf_q   <= ev_ovf_d;
    end
  end

  assign du_stall_i     = stall_i_q;
  assign bp_event_valid = ev_valid_q;
  assign bp_overflow    = ev_ovf_q;

endmodule

// File: rtl/osd_cdm_du_bridge.sv
// Bridge from CDM SPR requests to cycle-accurate CPU debug-unit bus accesses.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : CDM req/rsp handshake and du_* bus
//   cpu_stall_req   : host stall register value
//   stall_release   : pulse clearing the breakpoint hold
//   du_stall_i      : stall to CPU
//   du_stall_o      : CPU reports breakpoint/stalled
//   bp_event_*      : pending breakpoint event and its handshake
//   bp_overflow     : coalesced breakpoint hits
// Every du access is bounded by TIMEOUT_CYCLES strobe cycles; with
// REQUIRE_STALL set, accesses to a running core are refused with an error.
module osd_cdm_du_bridge
  import osd_cdm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned REQUIRE_STALL  = 1
) (
  input  logic                clk,
  input  logic                rst,
  osd_cdm_du_bridge_if.slave  bus,
  input  logic                cpu_stall_req,
  input  logic                stall_release,
  output logic                du_stall_i,
  input  logic                du_stall_o,
  output logic                bp_event_valid,
  input  logic                bp_event_ready,
  output logic                bp_overflow
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = BR_IDLE;
  localparam logic [1:0] S_ACCESS = BR_ACCESS;
  localparam logic [1:0] S_RESP   = BR_RESP;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  spr_rsp_t         rsp_q,       rsp_d;
  logic             stb_q,       stb_d;
  spr_req_t         du_req_q,    du_req_d;

  // Stall ownership and breakpoint events.
  osd_cdm_bp_event u_bp_event (
    .clk            (clk),
    .rst            (rst),
    .cpu_stall_req  (cpu_stall_req),
    .stall_release  (stall_release),
    .du_stall_o     (du_stall_o),
    .du_stall_i     (du_stall_i),
    .bp_event_valid (bp_event_valid),
    .bp_event_ready (bp_event_ready),
    .bp_overflow    (bp_overflow)
  );

  // Access FSM: next state, timeout counter and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsp_d    = rsp_q;
    stb_d    = stb_q;
    du_req_d = du_req_q;

    case (state_q)
      S_IDLE: begin
        rsp_d = '0;
        if (bus.req_valid && req_ready_q) begin
          if ((REQUIRE_STALL != 0) && !du_stall_i) begin
            rsp_d   = '{err: 1'b1, rdata: '0};
            state_d = S_RESP;
          end else begin
            du_req_d = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
            stb_d    = 1'b1;
            cnt_d    = '0;
            state_d  = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack beats a timeout falling on the same cycle.
        if (bus.du_ack_o) begin
          rsp_d    = '{err: 1'b0, rdata: (du_req_q.write ? '0 : bus.du_dat_o)};
          stb_d    = 1'b0;
          du_req_d = '0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_d    = '{err: 1'b1, rdata: '0};
          stb_d    = 1'b0;
          du_req_d = '0;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = '0;
          rsp_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d    = '0;
        rsp_d    = '0;
        stb_d    = 1'b0;
        du_req_d = '0;
        state_d  = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      stb_q       <= 1'b0;
      du_req_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      stb_q       <= stb_d;
      du_req_q    <= du_req_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.du_stb_i  = stb_q;
  assign bus.du_adr_i  = du_req_q.addr;
  assign bus.du_we_i   = du_req_q.write;
  assign bus.du_dat_i  = du_req_q.wdata;

endmodule

// File: tb/tb_osd_cdm_du_bridge.sv
// Self-checking bench for osd_cdm_du_bridge (TIMEOUT_CYCLES=8, REQUIRE_STALL=1).
module tb_osd_cdm_du_bridge;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic cpu_stall_req;
  logic stall_release;
  logic du_stall_i;
  logic du_stall_o;
  logic bp_event_valid;
  logic bp_event_ready;
  logic bp_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic stalled_m;

  always #5 clk = ~clk;

  osd_cdm_du_bridge_if bus ();

  osd_cdm_du_bridge #(.TIMEOUT_CYCLES(TMO), .REQUIRE_STALL(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cpu_stall_req  (cpu_stall_req),
    .stall_release  (stall_release),
    .du_stall_i     (du_stall_i),
    .du_stall_o     (du_stall_o),
    .bp_event_valid (bp_event_valid),
    .bp_event_ready (bp_event_ready),
    .bp_overflow    (bp_overflow)
  );

  function automatic logic [87:0] outs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, du_stall_i,
            bus.du_stb_i, bus.du_adr_i, bus.du_we_i, bus.du_dat_i, bp_event_valid, bp_overflow};
  endfunction

  task automatic set_stall(input logic v);
    cpu_stall_req = v;
    repeat (2) @(negedge clk);
    stalled_m = v;
  endtask

  // One SPR access; the bench plays the CPU bus target acking on strobe cycle ack_at.
  task automatic do_access(input string name, input logic we, input logic [15:0] addr,
                           input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                           input int hold);
    int exp_stb;
    logic exp_err;
    logic [31:0] exp_rd;
    int stb_cnt;
    int idx;
    bit got;
    if (!stalled_m) begin
      exp_stb = 0; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (ack_at >= 1 && ack_at <= int'(TMO)) begin
      exp_stb = ack_at; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd;
    end else begin
      exp_stb = TMO; exp_err = 1'b1; exp_rd = 32'h0;
    end

    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      $display("FAIL %s req_ready never seen", name);
      return;
    end
    n_pass++;

    bus.req_valid = 1'b1; bus.req_write = we; bus.req_addr = addr; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_write = ~we;
    bus.req_addr = 16'($urandom); bus.req_wdata = $urandom;

    stb_cnt = 0; got = 0; idx = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1; idx = i;
      end else begin
        if (bus.du_stb_i === 1'b1) begin
          stb_cnt++;
          n_checks++;
          if ({bus.du_adr_i, bus.du_we_i, bus.du_dat_i} !== {addr, we, wd})
            $display("FAIL %s du_fields got=%h/%b/%h exp=%h/%b/%h", name,
                     bus.du_adr_i, bus.du_we_i, bus.du_dat_i, addr, we, wd);
          else n_pass++;
          bus.du_ack_o = (stb_cnt == ack_at);
          bus.du_dat_o = (stb_cnt == ack_at) ? rd : $urandom;
        end else begin
          bus.du_ack_o = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.du_ack_o = 1'b0;

    n_checks++;
    if (!got) begin
      $display("FAIL %s rsp_valid never seen", name);
      return;
    end
    n_pass++;
    n_checks++;
    if (stb_cnt != exp_stb) $display("FAIL %s stb_cycles got=%0d exp=%0d", name, stb_cnt, exp_stb);
    else n_pass++;
    n_checks++;
    if (idx != exp_stb + 1) $display("FAIL %s rsp_latency got=%0d exp=%0d", name, idx, exp_stb + 1);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_err, bus.rsp_rdata, bus.du_stb_i} !== {exp_err, exp_rd, 1'b0})
      $display("FAIL %s rsp got err=%b rdata=%h stb=%b exp err=%b rdata=%h stb=0", name,
               bus.rsp_err, bus.rsp_rdata, bus.du_stb_i, exp_err, exp_rd);
    else n_pass++;

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready} !== {1'b1, exp_err, exp_rd, 1'b0})
        $display("FAIL %s rsp_hold got v=%b err=%b rdata=%h rdy=%b exp v=1 err=%b rdata=%h rdy=0",
                 name, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, exp_err, exp_rd);
      else n_pass++;
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.du_stb_i, bus.du_adr_i, bus.du_we_i, bus.du_dat_i} !==
        {1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 32'h0})
      $display("FAIL %s post_idle got v=%b rdy=%b stb=%b adr=%h we=%b dat=%h exp 0/1/0/0/0/0", name,
               bus.rsp_valid, bus.req_ready, bus.du_stb_i, bus.du_adr_i, bus.du_we_i, bus.du_dat_i);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs() !== 88'h0) $display("FAIL reset_outs got=%h exp=0", outs());
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_read();
    set_stall(1'b1);
    do_access("read_3ack", 1'b0, 16'h0010, 32'h0, 3, 32'hDEADBEEF, 1);
  endtask

  task automatic test_refused();
    set_stall(1'b0);
    do_access("refused_write", 1'b1, 16'h0020, 32'h12345678, 1, 32'hA5A5A5A5, 2);
  endtask

  task automatic test_timeout();
    set_stall(1'b1);
    do_access("timeout_read", 1'b0, 16'h0031, 32'h0, 0, 32'h11111111, 5);
    do_access("ack_at_limit", 1'b0, 16'h0032, 32'h0, TMO, 32'hCAFEF00D, 0);
    do_access("write_ack1", 1'b1, 16'h0033, 32'h87654321, 1, 32'hFFFFFFFF, 1);
  endtask

  task automatic test_random_access();
    for (int i = 0; i < 12; i++) begin
      logic s;
      s = ($urandom_range(0, 3) != 0);
      if (s !== stalled_m) set_stall(s);
      do_access("rand_access", 1'($urandom), 16'($urandom), $urandom,
                int'($urandom_range(0, TMO + 2)), $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_bp_event();
    set_stall(1'b0);
    du_stall_o = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bp_event_valid, bp_overflow} !== 2'b10)
      $display("FAIL bp_first_event got=%b%b exp=10", bp_event_valid, bp_overflow);
    else n_pass++;
    du_stall_o = 1'b0;
    @(negedge clk);
    n_checks++;
    if (du_stall_i !== 1'b1) $display("FAIL bp_stall_set got=%b exp=1", du_stall_i);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (du_stall_i !== 1'b1) $display("FAIL bp_stall_held got=%b exp=1", du_stall_i);
    else n_pass++;
    stall_release = 1'b1;
    @(negedge clk);
    stall_release = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({du_stall_i, bp_event_valid} !== 2'b01)
      $display("FAIL bp_released got stall=%b valid=%b exp stall=0 valid=1", du_stall_i, bp_event_valid);
    else n_pass++;
    bp_event_ready = 1'b1;
    @(negedge clk);
    bp_event_ready = 1'b0;
    n_checks++;
    if ({bp_event_valid, bp_overflow} !== 2'b00)
      $display("FAIL bp_consume got=%b%b exp=00", bp_event_valid, bp_overflow);
    else n_pass++;
  endtask

  task automatic test_bp_overflow();
    du_stall_o = 1'b1; @(negedge clk);
    du_stall_o = 1'b0; @(negedge clk);
    du_stall_o = 1'b1; @(negedge clk);
    du_stall_o = 1'b0; @(negedge clk);
    n_checks++;
    if ({bp_event_valid, bp_overflow} !== 2'b11)
      $display("FAIL bp_overflow got=%b%b exp=11", bp_event_valid, bp_overflow);
    else n_pass++;
    bp_event_ready = 1'b1; @(negedge clk);
    bp_event_ready = 1'b0;
    n_checks++;
    if ({bp_event_valid, bp_overflow} !== 2'b00)
      $display("FAIL bp_overflow_clear got=%b%b exp=00", bp_event_valid, bp_overflow);
    else n_pass++;

    // Hit coinciding with a consume: event stays pending without overflow.
    du_stall_o = 1'b1; @(negedge clk);
    du_stall_o = 1'b0; @(negedge clk);
    du_stall_o = 1'b1; bp_event_ready = 1'b1; @(negedge clk);
    du_stall_o = 1'b0; bp_event_ready = 1'b0;
    n_checks++;
    if ({bp_event_valid, bp_overflow} !== 2'b10)
      $display("FAIL bp_hit_on_consume got=%b%b exp=10", bp_event_valid, bp_overflow);
    else n_pass++;
    @(negedge clk);

    // Release and hit in the same cycle: hold stays set.
    du_stall_o = 1'b1; stall_release = 1'b1; @(negedge clk);
    du_stall_o = 1'b0; stall_release = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (du_stall_i !== 1'b1) $display("FAIL bp_set_beats_release got=%b exp=1", du_stall_i);
    else n_pass++;
    bp_event_ready = 1'b1; stall_release = 1'b1; @(negedge clk);
    bp_event_ready = 1'b0; stall_release = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({du_stall_i, bp_event_valid, bp_overflow} !== 3'b000)
      $display("FAIL bp_all_clear got=%b%b%b exp=000", du_stall_i, bp_event_valid, bp_overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    bit got;
    set_stall(1'b1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready === 1'b1) got = 1;
      else @(negedge clk);
    end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0044; bus.req_wdata = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.du_stb_i !== 1'b1) $display("FAIL rst_mid_stb got=%b exp=1", bus.du_stb_i);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== 88'h0) $display("FAIL rst_mid_outs got=%h exp=0", outs());
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.du_stb_i} !== 2'b00)
        $display("FAIL rst_mid_no_rsp got v=%b stb=%b exp 0/0", bus.rsp_valid, bus.du_stb_i);
      else n_pass++;
    end
    stalled_m = 1'b1;
    do_access("after_reset", 1'b0, 16'h0045, 32'h0, 2, 32'h5A5A1234, 1);
  endtask

  // Pending-event model: count hits since the last consume.
  task automatic test_random_bp();
    int pending;
    logic prev_o;
    logic o, r, rise, hs;
    pending = 0; prev_o = 1'b0;
    for (int i = 0; i < 80; i++) begin
      o = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      du_stall_o = o; bp_event_ready = r; stall_release = 1'($urandom);
      rise = o && !prev_o;
      hs = (pending > 0) && r;
      if (hs) pending = rise ? 1 : 0;
      else if (rise) pending++;
      prev_o = o;
      @(negedge clk);
      n_checks++;
      if ({bp_event_valid, bp_overflow} !== {1'(pending > 0), 1'(pending > 1)})
        $display("FAIL rand_bp got=%b%b exp=%b%b step=%0d", bp_event_valid, bp_overflow,
                 1'(pending > 0), 1'(pending > 1), i);
      else n_pass++;
    end
    du_stall_o = 1'b0; bp_event_ready = 1'b0; stall_release = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_stall_req = 1'b0; stall_release = 1'b0; du_stall_o = 1'b0;
    bp_event_ready = 1'b0; stalled_m = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.du_ack_o = 1'b0; bus.du_dat_o = '0;
    @(negedge clk);
    test_reset();
    test_read();
    test_refused();
    test_timeout();
    test_random_access();
    test_bp_event();
    test_bp_overflow();
    test_reset_mid_access();
    test_random_bp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
